bn_param_loader: RTL and testbench
==================================

# bn_param_loader

Loads per-channel batch-normalization scale (gamma) and shift (beta) parameters into a batchnorm stage. Parameters arrive as a serial word stream over a valid/ready handshake and are written into a shadow bank. A trailing XOR checksum word is then verified, and only on a match is the shadow bank committed atomically to the packed `gamma_packed`/`beta_packed` outputs. A failed or aborted load never disturbs the parameters the datapath is currently using.

## Interface
Parameters:
- `WIDTH`, 16: parameter word width (Q-format, `FRAC` fractional bits).
- `FRAC`, 8: fractional bits; sets the unity-gamma default `1<<FRAC`.
- `CHANNELS`, 48: number of channels; word index width is `$clog2(CHANNELS)`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: pulse that begins a load; honoured only in IDLE.
- `abort`, in, 1: cancels an in-progress load; no commit.
- `s_data`, in, `WIDTH`: parameter stream word.
- `s_valid`, in, 1: `s_data` valid.
- `s_ready`, out, 1: loader accepts a word; combinational from state.
- `gamma_packed`, out, `CHANNELS*WIDTH`: active gamma; channel i at `[i*WIDTH +: WIDTH]`.
- `beta_packed`, out, `CHANNELS*WIDTH`: active beta, same packing.
- `params_valid`, out, 1: at least one load has committed since reset.
- `busy`, out, 1: state is not IDLE.
- `load_done`, out, 1: one-cycle pulse on commit.
- `load_error`, out, 1: sticky checksum-mismatch flag; cleared by the next accepted `start`.

## Operation
- Stream order: gamma[0..CHANNELS-1], then beta[0..CHANNELS-1], then one checksum word. That is 2*CHANNELS+1 beats.
- A beat is accepted on a rising edge with `s_valid && s_ready`.
- Checksum: the XOR of all 2*CHANNELS parameter words, computed in a `WIDTH`-bit accumulator.
- States and transitions:
  - IDLE: `s_ready`=0. On `start`: clear idx and accumulator, clear `load_error`, go to GAMMA.
  - GAMMA: `s_ready`=1. Each beat writes `shadow_gamma[idx]` and XORs the word into the accumulator. When idx==CHANNELS-1, set idx=0 and go to BETA; otherwise idx++.
  - BETA: same as GAMMA, writing `shadow_beta`. After the last word, go to CHECK.
  - CHECK: `s_ready`=1. Accept one beat. If it equals the accumulator, go to COMMIT. Otherwise set `load_error`=1 and go to IDLE.
  - COMMIT: `s_ready`=0. Copy both shadow banks to the active outputs, set `params_valid`=1, pulse `load_done`, go to IDLE.
- `abort` has priority over beat acceptance in GAMMA, BETA and CHECK. It returns to IDLE with no commit and leaves `load_error` unchanged. In any other state `abort` has no effect.
- `start` outside IDLE is ignored.
- Partial, aborted or failed loads never alter `gamma_packed`, `beta_packed` or `params_valid`.
- Shadow contents are don't-care until they are committed.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE; `s_ready`=0, `busy`=0.
  - every gamma slot = `1<<FRAC` (0x0100); every beta slot = 0.
  - `params_valid`=0, `load_done`=0, `load_error`=0.
- Reset asserted mid-load discards the load and restores all reset values, including the active banks.
- `start` sampled at edge E0: GAMMA is entered after E0, so `s_ready`=1 and `busy`=1 in the following cycle.
- With continuous `s_valid`, beats are accepted on edges E1 through E(2C+1), where C=CHANNELS. For C=48 that is E1..E97.
- COMMIT occupies the cycle after E(2C+1). At edge E(2C+2):
  - the packed outputs and `params_valid` update;
  - `load_done` is high for exactly the one cycle after that edge;
  - state returns to IDLE.
- On a checksum mismatch at edge Ek, `load_error`=1 and `busy`=0 in the cycle after Ek.
- `s_valid` gaps stall the load without limit and with no timeout. Throughput is one word per cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release. Every gamma slot = 0x0100 and every beta slot = 0x0000. `params_valid`=0, `load_error`=0, `busy`=0, `s_ready`=0.
- **Clean load:** pulse `start`, then stream gamma[i]=0x0100+i and beta[i]=i for i=0..47, then checksum 0x0000, with `s_valid` held high. `load_done` pulses exactly 99 cycles after the `start` edge. `gamma_packed[47*16 +: 16]`=0x012F, `beta_packed[5*16 +: 16]`=0x0005, `params_valid`=1.
- **Backpressure:** repeat the clean load with `s_valid` low on every third cycle. The final outputs are identical to the clean load, and no word is lost or duplicated.
- **Bad checksum:** after the clean load, stream all gamma words = 0x0200 and all beta words = 0x0001, then checksum 0x0001. `load_error`=1 and `load_done` never pulses. The outputs still hold the clean-load values.
- **Abort and ignored start:**
  - Pulse `abort` after 20 beats, then send `start` plus a full valid stream of gamma=0x0080, beta=0, checksum 0x0000. The result is committed, with every gamma slot = 0x0080.
  - Pulse `start` during beat 10 of a load. It has no effect, and the load completes normally.
- **Reset mid-load:** assert `rst_n`=0 during the beta phase of a load. The outputs immediately return to their reset values (0x0100 and 0x0000), `params_valid`=0, and the state is IDLE.

Source files
------------

// File: rtl/bn_param_loader.sv
// Batch-norm gamma/beta parameter loader: streams words into a shadow bank,
// verifies a trailing XOR checksum and commits both banks atomically on a match.
module bn_param_loader #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [WIDTH-1:0]            s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [CHANNELS*WIDTH-1:0]   gamma_packed,
    output logic [CHANNELS*WIDTH-1:0]   beta_packed,
    output logic                        params_valid,
    output logic                        busy,
    output logic                        load_done,
    output logic                        load_error
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] GAMMA_ONE = WIDTH'(1) << FRAC;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAMMA,
        ST_BETA,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [WIDTH-1:0]            acc_q, acc_d;
    logic                        params_valid_q, params_valid_d;
    logic                        load_done_q, load_done_d;
    logic                        load_error_q, load_error_d;
    logic [CHANNELS*WIDTH-1:0]   gamma_q, gamma_d;
    logic [CHANNELS*WIDTH-1:0]   beta_q, beta_d;

    logic [WIDTH-1:0]            shadow_gamma_q [CHANNELS];
    logic [WIDTH-1:0]            shadow_gamma_d [CHANNELS];
    logic [WIDTH-1:0]            shadow_beta_q  [CHANNELS];
    logic [WIDTH-1:0]            shadow_beta_d  [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   shadow_gamma_flat;
    logic [CHANNELS*WIDTH-1:0]   shadow_beta_flat;

    logic                        wr_gamma;
    logic                        wr_beta;
    logic                        commit;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        params_valid_d = params_valid_q;
        load_error_d   = load_error_q;
        load_done_d    = 1'b0;
        wr_gamma       = 1'b0;
        wr_beta        = 1'b0;
        commit         = 1'b0;
        s_ready        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d        = '0;
                    acc_d        = '0;
                    load_error_d = 1'b0;
                    state_d      = ST_GAMMA;
                end
            end
            ST_GAMMA: begin
                s_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    wr_gamma = 1'b1;
                    acc_d    = acc_q ^ s_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_BETA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_BETA: begin
                s_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    wr_beta = 1'b1;
                    acc_d   = acc_q ^ s_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                s_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    if (s_data == acc_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                commit         = 1'b1;
                params_valid_d = 1'b1;
                load_done_d    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow slots carry no reset: their contents only matter once committed.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_shadow
        always_comb begin
            shadow_gamma_d[gi] = shadow_gamma_q[gi];
            shadow_beta_d[gi]  = shadow_beta_q[gi];
            if (wr_gamma && (idx_q == IDX_W'(gi))) begin
                shadow_gamma_d[gi] = s_data;
            end
            if (wr_beta && (idx_q == IDX_W'(gi))) begin
                shadow_beta_d[gi] = s_data;
            end
        end

        always_ff @(posedge clk) begin
            shadow_gamma_q[gi] <= shadow_gamma_d[gi];
            shadow_beta_q[gi]  <= shadow_beta_d[gi];
        end

        assign shadow_gamma_flat[gi*WIDTH +: WIDTH] = shadow_gamma_q[gi];
        assign shadow_beta_flat[gi*WIDTH +: WIDTH]  = shadow_beta_q[gi];
    end

    always_comb begin
        gamma_d = commit ? shadow_gamma_flat : gamma_q;
        beta_d  = commit ? shadow_beta_flat  : beta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            params_valid_q <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            gamma_q        <= {CHANNELS{GAMMA_ONE}};
            beta_q         <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            params_valid_q <= params_valid_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            gamma_q        <= gamma_d;
            beta_q         <= beta_d;
        end
    end

    assign gamma_packed = gamma_q;
    assign beta_packed  = beta_q;
    assign params_valid = params_valid_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed testbench for bn_param_loader: clean, backpressured, bad-checksum,
// aborted, ignored-start and reset-mid-load parameter loads.
module tb_bn_param_loader;

    localparam int C = 48;
    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [W-1:0]    s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [C*W-1:0]  gamma_packed;
    logic [C*W-1:0]  beta_packed;
    logic            params_valid;
    logic            busy;
    logic            load_done;
    logic            load_error;

    bn_param_loader #(.WIDTH(W), .FRAC(8), .CHANNELS(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .gamma_packed (gamma_packed),
        .beta_packed  (beta_packed),
        .params_valid (params_valid),
        .busy         (busy),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_g [C];
    logic [W-1:0] exp_b [C];
    logic [W-1:0] words [$];
    int          done_cyc;
    int          done_cnt;
    bit          err_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < C; i++) begin
            check($sformatf("%s_gamma%0d", tag, i), 32'(gamma_packed[i*W +: W]), 32'(exp_g[i]));
            check($sformatf("%s_beta%0d", tag, i), 32'(beta_packed[i*W +: W]), 32'(exp_b[i]));
        end
    endtask

    task automatic set_exp(input logic [W-1:0] gb, input bit ginc, input logic [W-1:0] bb, input bit binc);
        for (int i = 0; i < C; i++) begin
            exp_g[i] = gb + (ginc ? W'(i) : W'(0));
            exp_b[i] = bb + (binc ? W'(i) : W'(0));
        end
    endtask

    task automatic build_words(input logic [W-1:0] gb, input bit ginc,
                               input logic [W-1:0] bb, input bit binc, input logic [W-1:0] csum);
        words.delete();
        for (int i = 0; i < C; i++) words.push_back(gb + (ginc ? W'(i) : W'(0)));
        for (int i = 0; i < C; i++) words.push_back(bb + (binc ? W'(i) : W'(0)));
        words.push_back(csum);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic run_load(input bit gap3, input int abort_at, input int start_at, input int rst_at);
        int b = 0;
        int cyc = 0;
        bit stop = 0;
        bit v;
        done_cyc = -1;
        done_cnt = 0;
        err_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(s_ready), 1);
        check("start_err_clr", 32'(load_error), 0);
        while (b < words.size() && !stop && cyc < 1000) begin
            v = !(gap3 && (cyc % 3 == 0));
            s_valid = v;
            s_data  = words[b];
            if (b == start_at && v) start = 1'b1;
            if (b == abort_at) begin
                abort   = 1'b1;
                s_valid = 1'b1;
            end
            if (b == rst_at) begin
                rst_n = 1'b0;
                #1;
                stop = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                start = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                    stop  = 1;
                end else if (v) begin
                    b++;
                end
            end
        end
        s_valid = 1'b0;
        if (!stop) begin
            for (int k = 0; k < 8; k++) begin
                if (load_done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (load_error) err_seen = 1;
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        set_exp(16'h0100, 0, 16'h0000, 0);
        check_banks("rst");
        check("rst_params_valid", 32'(params_valid), 0);
        check("rst_load_error", 32'(load_error), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_load_done", 32'(load_done), 0);

        // Clean load
        build_words(16'h0100, 1, 16'h0000, 1, 16'h0000);
        run_load(0, -1, -1, -1);
        set_exp(16'h0100, 1, 16'h0000, 1);
        check("clean_done_cycle", 32'(done_cyc), 99);
        check("clean_done_pulses", 32'(done_cnt), 1);
        check("clean_no_error", 32'(err_seen), 0);
        check("clean_gamma47", 32'(gamma_packed[47*16 +: 16]), 32'h012F);
        check("clean_beta5", 32'(beta_packed[5*16 +: 16]), 32'h0005);
        check("clean_params_valid", 32'(params_valid), 1);
        check("clean_idle", 32'(busy), 0);
        check_banks("clean");
        $display("clean load: done at cycle %0d", done_cyc);

        // Backpressure: s_valid low every third cycle
        run_load(1, -1, -1, -1);
        check("bp_done_pulses", 32'(done_cnt), 1);
        check("bp_no_error", 32'(err_seen), 0);
        check_banks("bp");
        $display("backpressure load: done at cycle %0d", done_cyc);

        // Bad checksum: expected XOR is 0, sent 1
        build_words(16'h0200, 0, 16'h0001, 0, 16'h0001);
        run_load(0, -1, -1, -1);
        check("bad_load_error", 32'(load_error), 1);
        check("bad_done_pulses", 32'(done_cnt), 0);
        check("bad_idle", 32'(busy), 0);
        check("bad_params_valid", 32'(params_valid), 1);
        check_banks("bad");
        $display("bad checksum load: load_error=%0d", load_error);

        // Abort after 20 beats, then a full load of gamma=0x0080
        build_words(16'h0080, 0, 16'h0000, 0, 16'h0000);
        run_load(0, 20, -1, -1);
        check("abort_idle", 32'(busy), 0);
        check("abort_done_pulses", 32'(done_cnt), 0);
        check("abort_error_kept", 32'(load_error), 0);
        check_banks("abort");
        @(posedge clk); #1;
        check("abort_no_done", 32'(load_done), 0);
        run_load(0, -1, -1, -1);
        set_exp(16'h0080, 0, 16'h0000, 0);
        check("reload_done_pulses", 32'(done_cnt), 1);
        check_banks("reload");
        $display("abort then reload: done at cycle %0d", done_cyc);

        // start during beat 10 is ignored
        build_words(16'h0100, 1, 16'h0000, 1, 16'h0000);
        run_load(0, -1, 10, -1);
        set_exp(16'h0100, 1, 16'h0000, 1);
        check("ign_start_done_cycle", 32'(done_cyc), 99);
        check("ign_start_done_pulses", 32'(done_cnt), 1);
        check_banks("ign_start");
        $display("ignored start load: done at cycle %0d", done_cyc);

        // Reset during the beta phase
        build_words(16'h0200, 0, 16'h0003, 0, 16'h0000);
        run_load(0, -1, -1, 60);
        set_exp(16'h0100, 0, 16'h0000, 0);
        check_banks("midrst");
        check("midrst_params_valid", 32'(params_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_s_ready", 32'(s_ready), 0);
        check("midrst_load_error", 32'(load_error), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_after_busy", 32'(busy), 0);
        check("midrst_after_pv", 32'(params_valid), 0);
        $display("reset mid-load: params_valid=%0d busy=%0d", params_valid, busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
